tile_sched: RTL
===============

Name: tile_sched

Overview:
Sequencer for one ROWS x COLS systolic PE array.
Per tile it runs four steps: shift one weight tile down the columns into the background weight registers, issue the weight switch, stream num_vec input vectors into the west edge with per-row skew, then wait for the last partial sums to drain out of the south edge.
Sits between the tile buffers (weight and input RAMs, 1-cycle read latency) and the array wrapper.
Drives only the west-edge valid/switch, the broadcast weight-accept, the array enable and the mode.

Parameters:
ROWS, 4, array rows (weight rows per tile)
COLS, 4, array columns (sets drain length)
VEC_W, 16, width of the vector count and input address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a tile; sampled only in IDLE
abort  in  1  synchronous cancel; wins over everything except reset
num_vec  in  VEC_W  vector count M; must be >= 1
mode_in  in  2  array mode (00 Q8.8, 01 INT16, 10 INT8x2, 11 INT4x4)
sys_mode  out  2  mode latched at start; holds after done
pe_enable  out  1  array enable
w_rd_en  out  1  weight RAM read strobe
w_rd_addr  out  $clog2(ROWS)  weight row index
w_accept  out  1  broadcast accept_w to all PEs
in_rd_en  out  1  input RAM read strobe
in_rd_addr  out  VEC_W  vector index
row_valid  out  ROWS  west-edge valid per row, skewed
row_switch  out  ROWS  west-edge weight-switch per row, skewed
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
cfg_err  out  1  one-cycle pulse: start with num_vec == 0

Behaviour:
- Reset: all outputs 0 (including sys_mode); state IDLE; counters and skew lines cleared.
- States and transitions:
  - IDLE --start, M>=1--> LOAD_W.
  - LOAD_W (ROWS cycles) --> STREAM.
  - STREAM (M cycles) --> DRAIN.
  - DRAIN (ROWS+COLS cycles) --> DONE.
  - DONE (1 cycle) --> IDLE.
- Cycle numbering: cycle 0 is the cycle in which start is sampled.
- Latch at cycle 0: M and mode_in are captured; sys_mode updates at cycle 1.
- Start with M == 0: cfg_err = 1 in cycle 1; stays IDLE.
- LOAD_W, cycle 1+k (k = 0..ROWS-1):
  - w_rd_en = 1, w_rd_addr = ROWS-1-k.
  - w_accept is w_rd_en delayed one cycle, so it is high in cycles 2..ROWS+1.
  - Result: PE row r holds weight row r in its background register at the end of cycle ROWS+1.
- STREAM, cycle ROWS+1+j (j = 0..M-1): in_rd_en = 1, in_rd_addr = j.
- West-edge timing for row r:
  - row_valid[r] = in_rd_en delayed 1+r cycles.
  - row_switch[r] is high only on the first valid cycle of row r, i.e. cycle ROWS+2+r.
  - The input data skew is done by the wrapper using the same skew_line.
- Drain and completion:
  - Last south-edge psum is visible at cycle 2*ROWS+M+COLS.
  - done = 1 at cycle 2*ROWS+M+COLS+1; the FSM is then IDLE next cycle.
- busy and pe_enable are 1 in every non-IDLE state. Dropping pe_enable in IDLE clears the array.
- Ignored start: start while busy is ignored, including the DONE cycle.
- No overlap: back-to-back tiles do not overlap; the minimum start-to-start spacing is 2*ROWS+M+COLS+2 cycles.
- abort in any state:
  - Next cycle: IDLE, all strobes, skew lines, busy and pe_enable are 0.
  - No done pulse; sys_mode holds its value.
- Asynchronous reset mid-operation: same as the reset state above, immediately.
- Counters:
  - Load counter: $clog2(ROWS) bits.
  - Vector counter: VEC_W bits, compared against M-1; must not wrap at M = 2^VEC_W-1.
  - Drain counter: $clog2(ROWS+COLS+1) bits.

Decomposition:
- Package tpu_ctrl_pkg:
  - sched_state_t enum {IDLE, LOAD_W, STREAM, DRAIN, DONE}.
  - sys_mode_t (2-bit) with named constants MODE_Q88, MODE_INT16, MODE_INT8, MODE_INT4.
  - RAM_LAT = 1.
- One sub-module skew_line:
  - Parameter DEPTH; 2-bit shift register carrying {valid, switch}.
  - Async active-low reset plus synchronous clear (used on abort).
  - Instantiated ROWS times with DEPTH = 1+r.

Test Plan:
- ROWS=COLS=4, M=1, start at cycle 0:
  - w_rd_addr = 3,2,1,0 in cycles 1-4; w_accept in cycles 2-5.
  - in_rd_addr = 0 at cycle 5.
  - row_valid[r] = row_switch[r] = 1 at cycle 6+r only.
  - done at cycle 14; busy and pe_enable high in cycles 1-14.
- M=3:
  - in_rd_addr = 0,1,2 in cycles 5-7.
  - row_valid[3] high in cycles 9-11; row_switch[3] high at cycle 9 only.
  - done at cycle 16.
- start pulsed at cycles 3 and 16 of an M=3 tile: both ignored, no second tile; a start at cycle 17 launches a new tile.
- num_vec=0 with start: cfg_err = 1 at cycle 1; busy, w_rd_en and done stay 0.
- abort at cycle 6 of an M=3 tile:
  - Cycle 7: busy, pe_enable, row_valid and in_rd_en are all 0; no done ever.
  - A following start repeats scenario 2's timing exactly.
- mode_in=10 at start, then toggled: sys_mode = 10 from cycle 1 through done and after it. rst_n low mid-DRAIN: every output is 0 asynchronously.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the systolic-array tile sequencer.
package tpu_ctrl_pkg;

    // Sequencer phases for one weight tile.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sched_state_t;

    // Arithmetic mode forwarded to every PE.
    typedef logic [1:0] sys_mode_t;

    localparam sys_mode_t MODE_Q88   = 2'b00;
    localparam sys_mode_t MODE_INT16 = 2'b01;
    localparam sys_mode_t MODE_INT8  = 2'b10;
    localparam sys_mode_t MODE_INT4  = 2'b11;

    // Read latency of the weight and input tile buffers.
    localparam int RAM_LAT = 1;

endpackage

// File: rtl/tile_sched_skew_line.sv
// Per-row west-edge delay line carrying {valid, switch}.
// Row r uses DEPTH = RAM_LAT + r so that the diagonal wavefront enters the array.
module skew_line #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [1:0] d,
    output logic [1:0] q
);

    logic [1:0] pipe [DEPTH];

    // Shift register. A synchronous clear empties it in one cycle when a tile is abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= 2'b00;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= 2'b00;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/tile_sched.sv
// Tile sequencer for a ROWS x COLS systolic PE array.
// A tile runs four phases: load the weights, switch them in, stream the vectors, drain the partial sums.
module tile_sched
    import tpu_ctrl_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int VEC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [VEC_W-1:0]        num_vec,
    input  logic [1:0]              mode_in,
    output logic [1:0]              sys_mode,
    output logic                    pe_enable,
    output logic                    w_rd_en,
    output logic [$clog2(ROWS)-1:0] w_rd_addr,
    output logic                    w_accept,
    output logic                    in_rd_en,
    output logic [VEC_W-1:0]        in_rd_addr,
    output logic [ROWS-1:0]         row_valid,
    output logic [ROWS-1:0]         row_switch,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam int LD_W = $clog2(ROWS);
    localparam int DR_W = $clog2(ROWS + COLS + 1);

    localparam logic [LD_W-1:0] LD_LAST = LD_W'(ROWS - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(ROWS + COLS - 1);

    sched_state_t     state;
    logic [LD_W-1:0]  ld_cnt;
    logic [VEC_W-1:0] vec_cnt;
    logic [VEC_W-1:0] vec_last;
    logic [DR_W-1:0]  dr_cnt;
    sys_mode_t        mode_q;
    logic             launch;
    logic             first_vec;
    logic [1:0]       skew_q [ROWS];

    // A tile only launches from IDLE with a nonzero vector count and no simultaneous cancel.
    assign launch = (state == IDLE) && start && (num_vec != '0) && !abort;

    // Phase sequencing. Each counter is zeroed when its phase ends, so a fresh tile always starts clean.
    // The last vector index is stored instead of the count so M = 2^VEC_W-1 never needs a wider compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ld_cnt   <= '0;
            vec_cnt  <= '0;
            vec_last <= '0;
            dr_cnt   <= '0;
        end else if (abort) begin
            state   <= IDLE;
            ld_cnt  <= '0;
            vec_cnt <= '0;
            dr_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= LOAD_W;
                        vec_last <= num_vec - VEC_W'(1);
                        ld_cnt   <= '0;
                    end
                end
                LOAD_W: begin
                    if (ld_cnt == LD_LAST) begin
                        state   <= STREAM;
                        ld_cnt  <= '0;
                        vec_cnt <= '0;
                    end else begin
                        ld_cnt <= ld_cnt + LD_W'(1);
                    end
                end
                STREAM: begin
                    if (vec_cnt == vec_last) begin
                        state   <= DRAIN;
                        vec_cnt <= '0;
                        dr_cnt  <= '0;
                    end else begin
                        vec_cnt <= vec_cnt + VEC_W'(1);
                    end
                end
                DRAIN: begin
                    if (dr_cnt == DR_LAST) begin
                        state  <= DONE;
                        dr_cnt <= '0;
                    end else begin
                        dr_cnt <= dr_cnt + DR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Mode is captured at launch and held afterwards, even through an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_Q88;
        end else if (launch) begin
            mode_q <= sys_mode_t'(mode_in);
        end
    end

    // Weight accept trails the weight read strobe by the buffer latency.
    // A zero-length tile request is flagged one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_accept <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            w_accept <= w_rd_en && !abort;
            cfg_err  <= (state == IDLE) && start && (num_vec == '0) && !abort;
        end
    end

    // Strobes and addresses are decoded from the phase. Weight rows are read bottom row first so
    // that after ROWS shifts down the columns, row r sits in PE row r.
    always_comb begin
        busy       = (state != IDLE);
        pe_enable  = (state != IDLE);
        w_rd_en    = (state == LOAD_W);
        w_rd_addr  = '0;
        in_rd_en   = (state == STREAM);
        in_rd_addr = '0;
        done       = (state == DONE);
        if (state == LOAD_W) begin
            w_rd_addr = LD_LAST - ld_cnt;
        end
        if (state == STREAM) begin
            in_rd_addr = vec_cnt;
        end
    end

    assign sys_mode  = mode_q;
    assign first_vec = in_rd_en && (vec_cnt == '0);

    // One skew line per row. The switch travels with the first vector, so each PE row swaps
    // its weights exactly when the first input of the tile reaches it.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        skew_line #(
            .DEPTH(RAM_LAT + r)
        ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (abort),
            .d     ({in_rd_en, first_vec}),
            .q     (skew_q[r])
        );
        assign row_valid[r]  = skew_q[r][1];
        assign row_switch[r] = skew_q[r][0];
    end

endmodule
